// File: rtl/trap_report_pkg.sv
// Shared types and helpers for the end-of-run trap reporting controller.
package trap_report_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StReport = 2'd2,
    StDone   = 2'd3
  } state_e;

  // A timeout is reported as one past the highest real source index.
  function automatic logic [2:0] timeout_src(input int unsigned num_src);
    return 3'(num_src);
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/trap_prio_arb.sv
// Lowest-index-wins priority picker: one-hot grant, binary index and any-valid flag.
module trap_prio_arb #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [2:0]   idx,
  output logic         any_valid
);

  // Walk from the top so the lowest asserted request is the last one written.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = 3'(i);
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/trap_report_ctrl.sv
// Latches the first trap (or a cycle-limit timeout), freezes run counters, waits a
// drain window and then emits a single report pulse.
module trap_report_ctrl
  import trap_report_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned COMMIT_W     = 3,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [31:0] MAX_CYCLES   = 32'hFFFF_FFFF,
  parameter logic [31:0] TIMEOUT_CODE = 32'h0000_00FF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          trap_valid,
  input  logic [NUM_SRC*32-1:0]       trap_code,
  input  logic [NUM_SRC*32-1:0]       trap_pc,
  input  logic [NUM_SRC*COMMIT_W-1:0] commit_cnt,
  output logic                        report_valid,
  output logic [31:0]                 report_code,
  output logic [31:0]                 report_pc,
  output logic [31:0]                 report_cycles,
  output logic [31:0]                 report_instrs,
  output logic [2:0]                  report_src,
  output logic                        busy
);

  localparam int unsigned SumW = COMMIT_W + $clog2(NUM_SRC);

  state_e      state_q, state_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] drain_q, drain_d;
  logic [31:0] code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  src_q, src_d;

  logic [NUM_SRC-1:0] grant;
  logic [2:0]         win_idx;
  logic               any_trap;
  logic [31:0]        win_code, win_pc;
  logic [SumW-1:0]    commit_sum;
  logic [31:0]        cycle_inc, instr_inc;
  logic               timeout_hit;

  trap_prio_arb #(
    .N (NUM_SRC)
  ) u_arb (
    .req       (trap_valid),
    .grant     (grant),
    .idx       (win_idx),
    .any_valid (any_trap)
  );

  always_comb begin
    win_code   = '0;
    win_pc     = '0;
    commit_sum = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        win_code = trap_code[i*32 +: 32];
        win_pc   = trap_pc[i*32 +: 32];
      end
      commit_sum = commit_sum + SumW'(commit_cnt[i*COMMIT_W +: COMMIT_W]);
    end
  end

  assign cycle_inc   = sat_add32(cycle_q, 32'd1);
  assign instr_inc   = sat_add32(instr_q, 32'(commit_sum));
  assign timeout_hit = (MAX_CYCLES != 32'd0) && (cycle_q == MAX_CYCLES - 32'd1);

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q;
    instr_d = instr_q;
    drain_d = drain_q;
    code_d  = code_q;
    pc_d    = pc_q;
    src_d   = src_q;
    unique case (state_q)
      StRun: begin
        cycle_d = cycle_inc;
        instr_d = instr_inc;
        if (any_trap || timeout_hit) begin
          // A real trap beats a timeout landing on the same cycle.
          code_d  = any_trap ? win_code : TIMEOUT_CODE;
          pc_d    = any_trap ? win_pc : 32'd0;
          src_d   = any_trap ? win_idx : timeout_src(NUM_SRC);
          drain_d = '0;
          state_d = (DRAIN_CYCLES == 0) ? StReport : StDrain;
        end
      end
      StDrain: begin
        if (drain_q == DRAIN_CYCLES - 1) begin
          state_d = StReport;
        end else begin
          drain_d = drain_q + 32'd1;
        end
      end
      StReport: state_d = StDone;
      StDone:   state_d = StDone;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StRun;
      cycle_q <= '0;
      instr_q <= '0;
      drain_q <= '0;
      code_q  <= '0;
      pc_q    <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
      drain_q <= drain_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      src_q   <= src_d;
    end
  end

  // Counters run live in RUN; they only become report values once frozen.
  assign report_valid  = (state_q == StReport);
  assign busy          = (state_q == StDrain) || (state_q == StReport);
  assign report_cycles = (state_q == StRun) ? 32'd0 : cycle_q;
  assign report_instrs = (state_q == StRun) ? 32'd0 : instr_q;
  assign report_code   = code_q;
  assign report_pc     = pc_q;
  assign report_src    = src_q;

endmodule
